// File: rtl/pipe_hazard_scoreboard_if.sv
// rtl/pipe_hazard_scoreboard_if.sv - decoder-to-scoreboard issue/hazard bundle
// Forward select ports exist only when PIPE_FWD_EN is defined.
interface pipe_hazard_scoreboard_if #(
    parameter int AW = 5
`ifdef PIPE_FWD_EN
    ,
    parameter int DEPTH = 3
`endif
);
    logic          d_valid;
    logic [AW-1:0] d_ra1;
    logic [AW-1:0] d_ra2;
    logic [1:0]    d_read;
    logic [AW-1:0] d_wa1;
    logic [AW-1:0] d_wa2;
    logic [1:0]    d_write;
    logic          ex_cres;
    logic          flush;
    logic          stall;
    logic          issue;
    logic [3:0]    inflight;
    logic [15:0]   stall_cnt;
`ifdef PIPE_FWD_EN
    logic [DEPTH-1:0] fwd1_sel;
    logic [DEPTH-1:0] fwd2_sel;
`endif

    modport master (
        output d_valid, d_ra1, d_ra2, d_read, d_wa1, d_wa2, d_write, ex_cres, flush,
`ifdef PIPE_FWD_EN
        input  fwd1_sel, fwd2_sel,
`endif
        input  stall, issue, inflight, stall_cnt
    );

    modport slave (
        input  d_valid, d_ra1, d_ra2, d_read, d_wa1, d_wa2, d_write, ex_cres, flush,
`ifdef PIPE_FWD_EN
        output fwd1_sel, fwd2_sel,
`endif
        output stall, issue, inflight, stall_cnt
    );
endinterface

// File: rtl/pipe_hazard_scoreboard.sv
// rtl/pipe_hazard_scoreboard.sv - RAW hazard scoreboard with cancel, flush and stall counting
// Optional forwarding selects are built when PIPE_FWD_EN is defined.
module pipe_hazard_scoreboard #(
    parameter int AW          = 5,
    parameter int DEPTH       = 3,
    parameter int COND_STAGE  = 1,
    parameter int FLUSH_DEPTH = 1,
    parameter int WB_THROUGH  = 0
`ifdef PIPE_FWD_EN
    ,
    parameter int FWD_STAGE   = 1
`endif
) (
    input  logic                   clk,
    input  logic                   rst,
    pipe_hazard_scoreboard_if.slave bus
);
    localparam int CHK = (WB_THROUGH != 0) ? DEPTH - 1 : DEPTH;

    logic [DEPTH-1:0] r_v;
    logic [1:0]       r_we  [DEPTH];
    logic [AW-1:0]    r_wa1 [DEPTH];
    logic [AW-1:0]    r_wa2 [DEPTH];
    logic [3:0]       r_inflight;
    logic [15:0]      r_stall_cnt;

    logic [DEPTH-1:0] w_m1;
    logic [DEPTH-1:0] w_m2;
    logic [DEPTH-1:0] w_nv;
    logic [1:0]       w_nwe [DEPTH];
    logic             w_stall;
    logic             w_issue;

    always_comb begin
        w_m1 = '0;
        w_m2 = '0;
        for (int k = 0; k < CHK; k++) begin
            w_m1[k] = bus.d_read[0] & r_v[k] &
                      ((r_we[k][0] & (r_wa1[k] == bus.d_ra1)) |
                       (r_we[k][1] & (r_wa2[k] == bus.d_ra1)));
            w_m2[k] = bus.d_read[1] & r_v[k] &
                      ((r_we[k][0] & (r_wa1[k] == bus.d_ra2)) |
                       (r_we[k][1] & (r_wa2[k] == bus.d_ra2)));
        end
    end

`ifdef PIPE_FWD_EN
    localparam logic [DEPTH-1:0] ONE     = DEPTH'(1);
    localparam logic [DEPTH-1:0] FWD_LOW = DEPTH'((1 << FWD_STAGE) - 1);

    logic [DEPTH-1:0] w_y1;
    logic [DEPTH-1:0] w_y2;
    logic             w_s1;
    logic             w_s2;

    // Lowest set bit is the youngest producer; it alone decides the source.
    always_comb begin
        w_y1         = w_m1 & (~w_m1 + ONE);
        w_y2         = w_m2 & (~w_m2 + ONE);
        w_s1         = |(w_y1 & FWD_LOW);
        w_s2         = |(w_y2 & FWD_LOW);
        w_stall      = bus.d_valid & (w_s1 | w_s2);
        bus.fwd1_sel = (bus.d_valid & ~w_s1) ? w_y1 : '0;
        bus.fwd2_sel = (bus.d_valid & ~w_s2) ? w_y2 : '0;
    end
`else
    assign w_stall = bus.d_valid & (|{w_m1, w_m2});
`endif

    assign w_issue = bus.d_valid & ~w_stall & ~bus.flush;

    always_comb begin
        w_nv = '0;
        for (int k = 0; k < DEPTH; k++) begin
            w_nwe[k] = 2'b00;
        end
        w_nv[0]  = w_issue;
        w_nwe[0] = w_issue ? bus.d_write : 2'b00;
        for (int k = 1; k < DEPTH; k++) begin
            if (!(bus.flush && (k < FLUSH_DEPTH))) begin
                w_nv[k]  = r_v[k-1];
                w_nwe[k] = r_we[k-1];
                // Failed condition keeps the slot occupied but drops its writes.
                if ((k - 1 == COND_STAGE) && !bus.ex_cres) begin
                    w_nwe[k] = 2'b00;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_v         <= '0;
            r_inflight  <= '0;
            r_stall_cnt <= '0;
            for (int k = 0; k < DEPTH; k++) begin
                r_we[k] <= 2'b00;
            end
        end else begin
            r_v        <= w_nv;
            r_inflight <= 4'($countones(w_nv));
            for (int k = 0; k < DEPTH; k++) begin
                r_we[k] <= w_nwe[k];
            end
            if (w_stall && (r_stall_cnt != 16'hFFFF)) begin
                r_stall_cnt <= r_stall_cnt + 16'd1;
            end
        end
    end

    // Addresses are only meaningful under their write enables, so no reset.
    always_ff @(posedge clk) begin
        r_wa1[0] <= bus.d_wa1;
        r_wa2[0] <= bus.d_wa2;
        for (int k = 1; k < DEPTH; k++) begin
            r_wa1[k] <= r_wa1[k-1];
            r_wa2[k] <= r_wa2[k-1];
        end
    end

    assign bus.stall     = w_stall;
    assign bus.issue     = w_issue;
    assign bus.inflight  = r_inflight;
    assign bus.stall_cnt = r_stall_cnt;
endmodule
